exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 cause_in  in  3  cause code of the committing instruction: 3'b100 none, 3'b011 syscall, 3'b001 illegal opcode; any other code is a generic exception.
REQ-004 cause_valid  in  1  cause_in and pc_in are valid this cycle.
REQ-005 pc_in  in  32  PC of the committing instruction.
REQ-006 irq  in  4  external interrupt request lines, level-sensitive.
REQ-007 eret  in  1  return-from-handler request (driven by interrupts_j).
REQ-008 vec_wr  in  1  write handler vector (driven by interrupts_addr_add).
REQ-009 vec_data  in  32  new handler vector.
REQ-010 interrupts_signal  out  1  one-cycle pipeline flush pulse.
REQ-011 redirect_valid  out  1  one-cycle PC redirect strobe.
REQ-012 redirect_pc  out  32  redirect target, valid with redirect_valid.
REQ-013 epc  out  32  saved return PC.
REQ-014 cause_reg  out  3  cause of the last taken event.
REQ-015 irq_pending  out  4  latched pending interrupts.
REQ-016 irq_ack  out  4  one-hot acknowledge, one-cycle pulse.
REQ-017 in_handler  out  1  high while state is HANDLER.

Function
REQ-018 FSM states IDLE, FLUSH, REDIRECT, HANDLER, RFLUSH, RREDIRECT; one cycle each in FLUSH, REDIRECT, RFLUSH, RREDIRECT.
REQ-019 Synchronous event: cause_valid=1 and cause_in!=3'b100.
REQ-020 External event: any irq_pending bit set, state IDLE; lowest index wins.
REQ-021 In IDLE: synchronous event beats external event; either moves to FLUSH next cycle.
REQ-022 On taking an event in IDLE: cause_reg<=cause_in (sync) or 3'b101 (external); epc<=pc_in+4 for syscall, else pc_in; addition wraps modulo 2^32.
REQ-023 External event with cause_valid=0: epc<=pc_in regardless; irq_ack pulses for the winning bit in the same cycle the event is taken.
REQ-024 irq_pending[i] sets when irq[i]=1, clears on irq_ack[i]; set has priority over clear in the same cycle.
REQ-025 FLUSH: interrupts_signal=1; next REDIRECT.
REQ-026 REDIRECT: redirect_valid=1, redirect_pc=current vector register (includes a write in FLUSH); next HANDLER.
REQ-027 HANDLER: external events not taken (pending bits still latch); eret moves to RFLUSH.
REQ-028 HANDLER: synchronous event sets cause_reg<=3'b111 (double fault), epc unchanged, moves to FLUSH; beats simultaneous eret.
REQ-029 RFLUSH: interrupts_signal=1; next RREDIRECT. RREDIRECT: redirect_valid=1, redirect_pc=epc; next IDLE.
REQ-030 Events, eret arriving in FLUSH, REDIRECT, RFLUSH, RREDIRECT are ignored; eret in IDLE is ignored.
REQ-031 vec_wr updates the vector register in any state, effective next cycle.
REQ-032 interrupts_signal, redirect_valid, irq_ack are zero in all cases not listed above.

Reset
REQ-033 reset_n=0 asynchronously forces state IDLE, vector 32'h0000_0080, epc 0, cause_reg 3'b100, irq_pending 0, all strobes 0, in_handler 0, including mid-sequence.

Verification
REQ-034 Syscall: cause_in=3'b011, pc_in=32'h100 in IDLE -> flush next cycle, redirect_pc=32'h80 following cycle, epc=32'h104, cause_reg=3'b011.
REQ-035 Illegal opcode plus irq[1]=1 same cycle -> sync taken, cause_reg=3'b001, epc=pc_in, irq_pending[1] stays set, no irq_ack.
REQ-036 irq=4'b0110 in IDLE -> irq_ack=4'b0010, cause_reg=3'b101; eret in HANDLER -> flush, redirect_pc=epc, IDLE, then bit 2 taken.
REQ-037 In HANDLER, cause_in=3'b001 with eret -> cause_reg=3'b111, epc unchanged, redirect_pc=vector.
REQ-038 vec_wr=1, vec_data=32'h200 during FLUSH -> redirect_pc=32'h200; pc_in=32'hFFFF_FFFC syscall -> epc=0.
REQ-039 reset_n low during REDIRECT -> outputs at reset values immediately, no redirect_valid.

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception / interrupt controller: sequences flush and redirect for
// synchronous exceptions, external interrupts and return-from-handler.
module exception_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cause_in,
  input  logic        cause_valid,
  input  logic [31:0] pc_in,
  input  logic [3:0]  irq,
  input  logic        eret,
  input  logic        vec_wr,
  input  logic [31:0] vec_data,
  output logic        interrupts_signal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [2:0]  cause_reg,
  output logic [3:0]  irq_pending,
  output logic [3:0]  irq_ack,
  output logic        in_handler
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NIRQ = 4;
  localparam int unsigned CW   = 3;

  localparam logic [CW-1:0]   CAUSE_NONE    = 3'b100;
  localparam logic [CW-1:0]   CAUSE_SYSCALL = 3'b011;
  localparam logic [CW-1:0]   CAUSE_EXT     = 3'b101;
  localparam logic [CW-1:0]   CAUSE_DOUBLE  = 3'b111;
  localparam logic [XLEN-1:0] VEC_RESET     = 32'h0000_0080;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    REDIRECT  = 3'd2,
    HANDLER   = 3'd3,
    RFLUSH    = 3'd4,
    RREDIRECT = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] vec_q;
  logic [XLEN-1:0] epc_d;
  logic [XLEN-1:0] redirect_pc_d;
  logic [CW-1:0]   cause_d;
  logic [NIRQ-1:0] ack_d;
  logic [NIRQ-1:0] pending_d;
  logic [NIRQ-1:0] win_onehot;
  logic            flush_d;
  logic            redirect_d;
  logic            handler_d;
  logic            sync_evt;
  logic            ext_evt;

  // Event qualification and lowest-index interrupt selection
  always_comb begin
    sync_evt   = cause_valid && (cause_in != CAUSE_NONE);
    ext_evt    = |irq_pending;
    win_onehot = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_pending[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Pending latch: a new request outranks the acknowledge clearing it
  always_comb begin
    pending_d = (irq_pending & ~irq_ack) | irq;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    epc_d         = epc;
    cause_d       = cause_reg;
    ack_d         = '0;
    redirect_pc_d = redirect_pc;
    flush_d       = 1'b0;
    redirect_d    = 1'b0;
    handler_d     = 1'b0;

    case (state)
      IDLE: begin
        if (sync_evt) begin
          state_d = FLUSH;
          cause_d = cause_in;
          epc_d   = (cause_in == CAUSE_SYSCALL) ? XLEN'(pc_in + PC_STEP) : pc_in;
        end else if (ext_evt) begin
          state_d = FLUSH;
          cause_d = CAUSE_EXT;
          epc_d   = pc_in;
          ack_d   = win_onehot;
        end
      end
      FLUSH:     state_d = REDIRECT;
      REDIRECT:  state_d = HANDLER;
      HANDLER: begin
        if (sync_evt) begin
          state_d = FLUSH;
          cause_d = CAUSE_DOUBLE;
        end else if (eret) begin
          state_d = RFLUSH;
        end
      end
      RFLUSH:    state_d = RREDIRECT;
      RREDIRECT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    flush_d    = (state_d == FLUSH) || (state_d == RFLUSH);
    redirect_d = (state_d == REDIRECT) || (state_d == RREDIRECT);
    handler_d  = (state_d == HANDLER);

    // A vector write in the flush cycle must already steer the redirect
    if (state_d == REDIRECT) begin
      redirect_pc_d = vec_wr ? vec_data : vec_q;
    end else if (state_d == RREDIRECT) begin
      redirect_pc_d = epc;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Registered outputs, handler vector and pending interrupts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_q             <= VEC_RESET;
      epc               <= '0;
      cause_reg         <= CAUSE_NONE;
      irq_pending       <= '0;
      irq_ack           <= '0;
      interrupts_signal <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      in_handler        <= 1'b0;
    end else begin
      if (vec_wr) begin
        vec_q <= vec_data;
      end
      epc               <= epc_d;
      cause_reg         <= cause_d;
      irq_pending       <= pending_d;
      irq_ack           <= ack_d;
      interrupts_signal <= flush_d;
      redirect_valid    <= redirect_d;
      redirect_pc       <= redirect_pc_d;
      in_handler        <= handler_d;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus queues expected strobe
// cycles, a negedge monitor pops and compares every strobe the DUT shows.
module tb_exception_ctrl;

  typedef struct packed {
    logic        fl;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic [3:0]  ack;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  cause_in;
  logic        cause_valid;
  logic [31:0] pc_in;
  logic [3:0]  irq;
  logic        eret;
  logic        vec_wr;
  logic [31:0] vec_data;
  logic        interrupts_signal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [2:0]  cause_reg;
  logic [3:0]  irq_pending;
  logic [3:0]  irq_ack;
  logic        in_handler;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  exception_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cause_in         (cause_in),
    .cause_valid      (cause_valid),
    .pc_in            (pc_in),
    .irq              (irq),
    .eret             (eret),
    .vec_wr           (vec_wr),
    .vec_data         (vec_data),
    .interrupts_signal(interrupts_signal),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .epc              (epc),
    .cause_reg        (cause_reg),
    .irq_pending      (irq_pending),
    .irq_ack          (irq_ack),
    .in_handler       (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every strobe cycle must match the head of the expected queue
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (interrupts_signal || redirect_valid || (irq_ack != 4'b0))) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got fl=%0b rv=%0b rpc=%h epc=%h cause=%b ack=%b, required none",
                   interrupts_signal, redirect_valid, redirect_pc, epc, cause_reg, irq_ack);
        end else begin
          e = exp_q.pop_front();
          if (interrupts_signal !== e.fl || redirect_valid !== e.rv ||
              epc !== e.epc || cause_reg !== e.cause || irq_ack !== e.ack ||
              (e.rv && redirect_pc !== e.rpc)) begin
            n_fail++;
            $display("FAIL strobe_event: got fl=%0b rv=%0b rpc=%h epc=%h cause=%b ack=%b, required fl=%0b rv=%0b rpc=%h epc=%h cause=%b ack=%b",
                     interrupts_signal, redirect_valid, redirect_pc, epc, cause_reg, irq_ack,
                     e.fl, e.rv, e.rpc, e.epc, e.cause, e.ack);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drive one cycle of inputs; pc_in is left in place afterwards
  task automatic step(input logic cv, input logic [2:0] c, input logic [31:0] pc,
                      input logic [3:0] ir, input logic er, input logic vw,
                      input logic [31:0] vd);
    cause_valid = cv; cause_in = c; pc_in = pc; irq = ir; eret = er;
    vec_wr = vw; vec_data = vd;
    tick();
    cause_valid = 1'b0; cause_in = 3'b100; irq = 4'b0; eret = 1'b0;
    vec_wr = 1'b0; vec_data = 32'h0;
  endtask

  task automatic push(input logic fl, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_epc, input logic [2:0] c, input logic [3:0] ack);
    ev_t e;
    e.fl = fl; e.rv = rv; e.rpc = rpc; e.epc = e_epc; e.cause = c; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic take_pair(input logic [31:0] vec, input logic [31:0] e_epc,
                           input logic [2:0] c, input logic [3:0] ack);
    push(1'b1, 1'b0, 32'h0, e_epc, c, ack);
    push(1'b0, 1'b1, vec, e_epc, c, 4'b0);
  endtask

  task automatic ret_pair(input logic [31:0] e_epc, input logic [2:0] c);
    push(1'b1, 1'b0, 32'h0, e_epc, c, 4'b0);
    push(1'b0, 1'b1, e_epc, e_epc, c, 4'b0);
  endtask

  task automatic do_eret();
    step(1'b0, 3'b100, pc_in, 4'b0, 1'b1, 1'b0, 32'h0);
  endtask

  // From HANDLER: eret, then two cycles to land back in IDLE
  task automatic do_return(input logic [31:0] e_epc, input logic [2:0] c);
    ret_pair(e_epc, c);
    do_eret();
    idle(2);
  endtask

  initial begin
    reset_n = 1'b0; cause_in = 3'b100; cause_valid = 1'b0; pc_in = 32'h0;
    irq = 4'b0; eret = 1'b0; vec_wr = 1'b0; vec_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_epc", epc, 32'h0);
    check("reset_cause", 32'(cause_reg), 32'h4);
    check("reset_pending", 32'(irq_pending), 32'h0);
    check("reset_in_handler", 32'(in_handler), 32'h0);
    check("reset_redirect_valid", 32'(redirect_valid), 32'h0);
    check("reset_flush", 32'(interrupts_signal), 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // Syscall: epc is pc+4, redirect to reset vector
    take_pair(32'h80, 32'h104, 3'b011, 4'b0);
    step(1'b1, 3'b011, 32'h100, 4'b0, 1'b0, 1'b0, 32'h0);
    idle(2);
    check("syscall_in_handler", 32'(in_handler), 32'h1);
    check("syscall_epc", epc, 32'h104);
    do_return(32'h104, 3'b011);

    // Illegal opcode with simultaneous irq[1]: sync wins, irq stays pending
    take_pair(32'h80, 32'h200, 3'b001, 4'b0);
    step(1'b1, 3'b001, 32'h200, 4'b0010, 1'b0, 1'b0, 32'h0);
    idle(2);
    check("illegal_pending_kept", 32'(irq_pending), 32'h2);
    ret_pair(32'h200, 3'b001);
    do_eret();
    idle(2);
    take_pair(32'h80, 32'h200, 3'b101, 4'b0010);
    idle(3);
    check("irq1_pending_cleared", 32'(irq_pending), 32'h0);
    check("irq1_cause", 32'(cause_reg), 32'h5);
    do_return(32'h200, 3'b101);

    // Two interrupts: bit 1 first, bit 2 after return
    take_pair(32'h80, 32'h300, 3'b101, 4'b0010);
    step(1'b0, 3'b100, 32'h300, 4'b0110, 1'b0, 1'b0, 32'h0);
    idle(3);
    check("irq_bit2_still_pending", 32'(irq_pending), 32'h4);
    ret_pair(32'h300, 3'b101);
    do_eret();
    idle(2);
    take_pair(32'h80, 32'h300, 3'b101, 4'b0100);
    idle(3);
    check("irq_all_cleared", 32'(irq_pending), 32'h0);
    do_return(32'h300, 3'b101);

    // Double fault beats eret in HANDLER
    take_pair(32'h80, 32'h400, 3'b010, 4'b0);
    step(1'b1, 3'b010, 32'h400, 4'b0, 1'b0, 1'b0, 32'h0);
    idle(2);
    take_pair(32'h80, 32'h400, 3'b111, 4'b0);
    step(1'b1, 3'b001, 32'h500, 4'b0, 1'b1, 1'b0, 32'h0);
    idle(2);
    check("double_fault_epc", epc, 32'h400);
    do_return(32'h400, 3'b111);

    // IDLE ignores cause 'none' and eret
    step(1'b1, 3'b100, 32'h600, 4'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 3'b100, 32'h600, 4'b0, 1'b1, 1'b0, 32'h0);
    idle(2);
    check("idle_ignore_cause", 32'(cause_reg), 32'h7);
    check("idle_ignore_handler", 32'(in_handler), 32'h0);

    // Vector write during FLUSH, syscall epc wraps to 0
    take_pair(32'h200, 32'h0, 3'b011, 4'b0);
    step(1'b1, 3'b011, 32'hFFFF_FFFC, 4'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 3'b100, pc_in, 4'b0, 1'b0, 1'b1, 32'h200);
    idle(1);
    check("wrap_epc", epc, 32'h0);
    do_return(32'h0, 3'b011);

    // New vector persists; an event during FLUSH is ignored
    take_pair(32'h200, 32'h10, 3'b110, 4'b0);
    step(1'b1, 3'b110, 32'h10, 4'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 3'b011, 32'h999, 4'b0, 1'b0, 1'b0, 32'h0);
    idle(1);
    check("flush_ignore_cause", 32'(cause_reg), 32'h6);
    do_return(32'h10, 3'b110);

    // Reset during REDIRECT
    push(1'b1, 1'b0, 32'h0, 32'h24, 3'b011, 4'b0);
    step(1'b1, 3'b011, 32'h20, 4'b0, 1'b0, 1'b0, 32'h0);
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    check("rst_flush", 32'(interrupts_signal), 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", 32'(cause_reg), 32'h4);
    check("rst_in_handler", 32'(in_handler), 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    take_pair(32'h80, 32'h24, 3'b011, 4'b0);
    step(1'b1, 3'b011, 32'h20, 4'b0, 1'b0, 1'b0, 32'h0);
    idle(2);
    do_return(32'h24, 3'b011);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
